// File: rtl/cpu_loader.sv
// Boot loader: holds the core in reset, writes a byte-streamed image into instruction memory, then releases the core.
// Optional trailing checksum byte enabled by defining CPU_LOADER_CHECKSUM_EN.
module cpu_loader #(
    parameter int width       = 16,
    parameter int iaddr_width = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   start,
    output logic [iaddr_width-1:0] imem_addr,
    output logic [width-1:0]       imem_wdata,
    output logic                   imem_we,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        CNT_LO, CNT_HI, W_LO, W_HI, CSUM, LAST, RUN, ERR
    } state_t;

    state_t                 state, state_nxt;
    logic [15:0]            cnt;
    logic [15:0]            n_now;
    logic [7:0]             lo_byte;
    logic [iaddr_width:0]   widx;
    logic                   xfer;
    logic                   last_word;
`ifdef CPU_LOADER_CHECKSUM_EN
    logic [7:0]             csum;
    logic [7:0]             csum_nxt;
    assign csum_nxt = csum + rx_data;
`endif

    assign xfer      = rx_valid & rx_ready;
    assign n_now     = {rx_data, cnt[7:0]};
    // Index is one bit wider than the address so a full 2**iaddr_width image never wraps.
    assign last_word = (32'(widx) + 32'd1) == 32'(cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CNT_LO;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        case (state)
            CNT_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = CNT_HI;
            end
            CNT_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (32'(n_now) > (32'd1 << iaddr_width)) state_nxt = ERR;
`ifdef CPU_LOADER_CHECKSUM_EN
                    else if (n_now == 16'd0)                 state_nxt = CSUM;
`else
                    else if (n_now == 16'd0)                 state_nxt = LAST;
`endif
                    else                                     state_nxt = W_LO;
                end
            end
            W_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = W_HI;
            end
            W_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
`ifdef CPU_LOADER_CHECKSUM_EN
                    state_nxt = last_word ? CSUM : W_LO;
`else
                    state_nxt = last_word ? LAST : W_LO;
`endif
                end
            end
`ifdef CPU_LOADER_CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = (csum_nxt == 8'h00) ? LAST : ERR;
            end
`endif
            // One idle cycle so the final write lands before the core leaves reset.
            LAST:    state_nxt = RUN;
            RUN:     if (start) state_nxt = CNT_LO;
            ERR:     if (start) state_nxt = CNT_LO;
            default: state_nxt = ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            lo_byte    <= '0;
            widx       <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            imem_we    <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we   <= 1'b0;
            cpu_reset <= (state_nxt != RUN);
            done      <= (state_nxt == RUN);
            error     <= (state_nxt == ERR);
            if (xfer) begin
                case (state)
                    CNT_LO: cnt[7:0]  <= rx_data;
                    CNT_HI: cnt[15:8] <= rx_data;
                    W_LO:   lo_byte   <= rx_data;
                    W_HI: begin
                        imem_we    <= 1'b1;
                        imem_wdata <= {rx_data, lo_byte};
                        imem_addr  <= widx[iaddr_width-1:0];
                        widx       <= widx + 1'b1;
                    end
                    default: ;
                endcase
`ifdef CPU_LOADER_CHECKSUM_EN
                csum <= csum_nxt;
`endif
            end
            if ((state == RUN || state == ERR) && start) begin
                widx <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: expected writes are queued as images are built, a monitor pops them on imem_we.
module tb_cpu_loader;
    localparam int IAW = 10;
`ifdef CPU_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic           start;
    logic [IAW-1:0] imem_addr;
    logic [15:0]    imem_wdata;
    logic           imem_we;
    logic           cpu_reset;
    logic           done;
    logic           error;

    cpu_loader #(.width(16), .iaddr_width(IAW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .start(start), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_we(imem_we), .cpu_reset(cpu_reset),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IAW-1:0] a;
        logic [15:0]    d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b0 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.a));
                chk("write_data", 32'(imem_wdata), 32'(e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            chk("stall_rx_ready", 32'(rx_ready), 32'd1);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL rx_ready_timeout: got rx_ready=%0b, expected 1 within 50 cycles", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic begin_img(input logic [15:0] n);
        bq.delete();
        bq.push_back(n[7:0]);
        bq.push_back(n[15:8]);
    endtask

    task automatic add_word(input logic [IAW-1:0] a, input logic [15:0] d);
        wr_t e;
        bq.push_back(d[7:0]);
        bq.push_back(d[15:8]);
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send_all(input bit gapped, input bit add_csum);
        logic [7:0] s;
        s = 8'h00;
        if (add_csum) begin
`ifdef CPU_LOADER_CHECKSUM_EN
            foreach (bq[i]) s = s + bq[i];
            bq.push_back(8'h00 - s);
`endif
        end
        foreach (bq[i]) send_byte(bq[i], gapped ? ((i * 7 + 3) % 4) : 0);
    endtask

    // Called at the negedge following the final byte: LAST now, RUN next cycle.
    task automatic expect_release(input bit strobe);
        chk("last_strobe",    32'(imem_we),   32'(strobe));
        chk("last_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("last_rx_ready",  32'(rx_ready),  32'd0);
        chk("last_done",      32'(done),      32'd0);
        @(negedge clk);
        chk("run_cpu_reset",  32'(cpu_reset), 32'd0);
        chk("run_done",       32'(done),      32'd1);
        chk("run_rx_ready",   32'(rx_ready),  32'd0);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_done",      32'(done),      32'd0);
        chk("reload_error",     32'(error),     32'd0);
        chk("reload_rx_ready",  32'(rx_ready),  32'd1);
    endtask

    task automatic image1(input bit gapped);
        begin_img(16'd2);
        add_word(10'd0, 16'h1234);
        add_word(10'd1, 16'hABCD);
        send_all(gapped, 1'b1);
        expect_release(!CSUM_ON);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rx_ready",  32'(rx_ready),   32'd1);
        chk("rst_imem_addr", 32'(imem_addr),  32'd0);
        chk("rst_wdata",     32'(imem_wdata), 32'd0);
        chk("rst_we",        32'(imem_we),    32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset),  32'd1);
        chk("rst_done",      32'(done),       32'd0);
        chk("rst_error",     32'(error),      32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic two-word image, then the same image with rx_valid gaps after a reload.
        image1(1'b0);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_done",      32'(done),      32'd0);
        image1(1'b1);

        // Empty image.
        pulse_start();
        begin_img(16'd0);
        send_all(1'b0, 1'b1);
        expect_release(1'b0);

        // Largest image: every address written exactly once.
        pulse_start();
        begin_img(16'h0400);
        for (int i = 0; i < 1024; i++) add_word(IAW'(i), 16'((i * 16'h0123) ^ 16'h5A5A));
        send_all(1'b0, 1'b1);
        expect_release(!CSUM_ON);

        // Oversized count aborts straight after the second byte.
        pulse_start();
        begin_img(16'h0401);
        send_all(1'b0, 1'b0);
        chk("ovf_error",     32'(error),     32'd1);
        chk("ovf_rx_ready",  32'(rx_ready),  32'd0);
        chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        pulse_start();

`ifdef CPU_LOADER_CHECKSUM_EN
        begin_img(16'd1);
        add_word(10'd0, 16'h2211);
        bq.push_back(8'hCC);
        send_all(1'b0, 1'b0);
        expect_release(1'b0);
        pulse_start();
        begin_img(16'd1);
        add_word(10'd0, 16'h2211);
        bq.push_back(8'hCD);
        send_all(1'b0, 1'b0);
        chk("bad_csum_error",     32'(error),     32'd1);
        chk("bad_csum_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("bad_csum_held",      32'(cpu_reset), 32'd1);
        chk("bad_csum_writes",    32'(exp_q.size()), 32'd0);
        pulse_start();
`endif

        // Reset in the middle of a load discards the partial image.
        bq.delete();
        bq.push_back(8'h02);
        bq.push_back(8'h00);
        bq.push_back(8'h34);
        send_all(1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rx_ready",  32'(rx_ready),  32'd1);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_addr",      32'(imem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        image1(1'b0);
        pulse_start();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish within 2 ms");
        $fatal(1, "timeout");
    end

endmodule
